// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg
// Shared definitions for the camera framebuffer writer:
//   - default capture geometry (160x120)
//   - SPRAM word/address/mask widths and the two write masks used
//   - FSM state encoding
//   - the packed SPRAM write record carried through the FIFO
//   - RGB565 -> RGB222 conversion (top two bits of each channel)
package fb_writer_pkg;

  localparam int H_PIX_DEFAULT = 160;
  localparam int V_PIX_DEFAULT = 120;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int MASK_W = 4;

  // Bit positions of the most significant bit of each RGB565 channel
  localparam int R_HI    = 15;
  localparam int G_HI    = 10;
  localparam int B_HI    = 4;
  localparam int CH_BITS = 2;

  localparam logic [MASK_W-1:0] MASK_FULL = 4'b1111;
  localparam logic [MASK_W-1:0] MASK_LOW  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } fbState_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } fbWord_t;

  // Keeps the two most significant bits of R, G and B and zero-extends
  // the resulting 6-bit colour to a byte.
  function automatic logic [7:0] rgb565ToRgb222(input logic [15:0] pix);
    return {2'b00, pix[R_HI -: CH_BITS], pix[G_HI -: CH_BITS], pix[B_HI -: CH_BITS]};
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// fb_fifo
// Small synchronous FIFO with full/empty flags.
// Ports:
//   clk_i    clock, all logic on rising edge
//   reset_i  synchronous active-high reset (empties the FIFO)
//   flush_i  synchronous discard of all entries (wins over push/pop)
//   push_i   write data_i; ignored when full unless a pop happens too
//   pop_i    advance the head; ignored when empty
//   data_i   entry to write
//   data_o   current head entry (valid when !empty_o)
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
// DEPTH must be a power of two (>= 2).
module fb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so equal low bits mean either
  // empty (same wrap) or full (different wrap).
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A push into a full FIFO still fits when the head leaves the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);
  assign data_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer update; reset and flush both drop every stored entry.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fb_writer.sv
// fb_writer
// Captures a camera frame of RGB565 pixels, converts each pixel to an
// RGB222 byte, packs pixel pairs into 16-bit words and writes them to
// SPRAM whenever the shared write port is granted.
// Ports:
//   clk_i, reset_i             clock and synchronous active-high reset
//   frame_start_i/frame_end_i  one-cycle frame delimiters
//   pix_valid_i, pix_data_i    pixel strobe and RGB565 data
//   sp_grant_i                 SPRAM write port available this cycle
//   sp_addr_o/sp_wdata_o       registered SPRAM word address/data
//   sp_maskwe_o/sp_we_o        registered nibble mask and write enable
//   frame_count_o              completed frames (wraps)
//   busy_o                     capturing or flushing
//   overflow_o                 sticky: a packed word was dropped
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int H_PIX      = H_PIX_DEFAULT,
  parameter int V_PIX      = V_PIX_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_start_i,
  input  logic              pix_valid_i,
  input  logic [15:0]       pix_data_i,
  input  logic              frame_end_i,
  input  logic              sp_grant_i,
  output logic [ADDR_W-1:0] sp_addr_o,
  output logic [DATA_W-1:0] sp_wdata_o,
  output logic [MASK_W-1:0] sp_maskwe_o,
  output logic              sp_we_o,
  output logic [7:0]        frame_count_o,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int TOTAL = H_PIX * V_PIX;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL);

  fbState_t         state_q, state_d;
  logic [IDX_W-1:0] pixIdx_q, pixIdx_d;
  logic [7:0]       lowByte_q, lowByte_d;
  logic             pushValid_q, pushValid_d;
  fbWord_t          pushWord_q, pushWord_d;
  fbWord_t          spWord_q;
  logic             spWe_q;
  logic [7:0]       frameCount_q;
  logic             overflow_q;

  logic             accept;
  logic             abort;
  logic [IDX_W-1:0] newIdx;
  logic [7:0]       pixByte;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             popEn;
  logic             dropWord;
  fbWord_t          fifoHead;

  assign pixByte = rgb565ToRgb222(pix_data_i);

  // Next-state logic. A completed pixel pair (or the trailing odd pixel
  // on entry to FLUSH) is staged in pushWord for one cycle, so the word
  // reaches the FIFO on the cycle after the pixel that finished it.
  always_comb begin
    state_d     = state_q;
    pixIdx_d    = pixIdx_q;
    lowByte_d   = lowByte_q;
    pushValid_d = 1'b0;
    pushWord_d  = pushWord_q;
    accept      = 1'b0;
    abort       = 1'b0;
    newIdx      = pixIdx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start_i) begin
          state_d  = ST_CAPTURE;
          pixIdx_d = '0;
        end
      end

      ST_CAPTURE: begin
        if (frame_start_i) begin
          abort    = 1'b1;
          pixIdx_d = '0;
        end else begin
          accept = pix_valid_i && (pixIdx_q < LAST_IDX);
          newIdx = pixIdx_q + {{(IDX_W-1){1'b0}}, accept};
          if (accept) begin
            pixIdx_d = newIdx;
            if (!pixIdx_q[0]) begin
              lowByte_d = pixByte;
            end else begin
              pushValid_d = 1'b1;
              pushWord_d  = '{addr: ADDR_W'(pixIdx_q >> 1),
                              data: {pixByte, lowByte_q},
                              mask: MASK_FULL};
            end
          end
          // An odd count here can only come from an unpaired even pixel,
          // which is either this cycle's pixel or the one held in lowByte.
          if (frame_end_i || (newIdx == LAST_IDX)) begin
            state_d = ST_FLUSH;
            if (newIdx[0]) begin
              pushValid_d = 1'b1;
              pushWord_d  = '{addr: ADDR_W'(newIdx >> 1),
                              data: {8'h00, (accept ? pixByte : lowByte_q)},
                              mask: MASK_LOW};
            end
          end
        end
      end

      ST_FLUSH: begin
        if (frame_start_i) begin
          abort    = 1'b1;
          pixIdx_d = '0;
          state_d  = ST_CAPTURE;
        end else if (fifoEmpty && !pushValid_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        pixIdx_d = '0;
        state_d  = frame_start_i ? ST_CAPTURE : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Pops are suppressed during an abort so nothing from the discarded
  // frame can reach SPRAM; a push that cannot fit is counted as a drop.
  assign popEn    = sp_grant_i && !fifoEmpty && !abort;
  assign dropWord = pushValid_q && fifoFull && !popEn && !abort;

  fb_fifo #(
    .WIDTH ($bits(fbWord_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (abort),
    .push_i  (pushValid_q),
    .pop_i   (popEn),
    .data_i  (pushWord_q),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // State, capture and SPRAM output registers. The write port fields
  // hold their last value between writes; only sp_we pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      pixIdx_q     <= '0;
      lowByte_q    <= '0;
      pushValid_q  <= 1'b0;
      pushWord_q   <= '0;
      spWord_q     <= '0;
      spWe_q       <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q     <= state_d;
      pixIdx_q    <= pixIdx_d;
      lowByte_q   <= lowByte_d;
      pushValid_q <= pushValid_d;
      pushWord_q  <= pushWord_d;
      spWe_q      <= popEn;
      if (popEn) spWord_q <= fifoHead;
      if (state_q == ST_DONE) frameCount_q <= frameCount_q + 8'd1;
    end
  end

  // Sticky drop flag; every frame_start begins a fresh observation window.
  always_ff @(posedge clk_i) begin
    if (reset_i || frame_start_i) begin
      overflow_q <= 1'b0;
    end else if (dropWord) begin
      overflow_q <= 1'b1;
    end
  end

  assign sp_addr_o     = spWord_q.addr;
  assign sp_wdata_o    = spWord_q.data;
  assign sp_maskwe_o   = spWord_q.mask;
  assign sp_we_o       = spWe_q;
  assign frame_count_o = frameCount_q;
  assign busy_o        = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
  assign overflow_o    = overflow_q;

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter H_PIX, default 160: pixels per captured line.
REQ-002 Parameter V_PIX, default 120: lines per captured frame.
REQ-003 Parameter FIFO_DEPTH, default 4: packed-word FIFO entries, power of two.
REQ-004 clk  in  1  single clock (clk_25MHz domain); all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse marking the start of a camera frame.
REQ-007 pix_valid  in  1  one-cycle strobe; pix_data is valid this cycle.
REQ-008 pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
REQ-009 frame_end  in  1  one-cycle pulse marking the end of a camera frame.
REQ-010 sp_grant  in  1  SPRAM write port available this cycle (the display reader owns it otherwise).
REQ-011 sp_addr  out  14  SPRAM word address.
REQ-012 sp_wdata  out  16  SPRAM write data.
REQ-013 sp_maskwe  out  4  SPRAM nibble write mask.
REQ-014 sp_we  out  1  SPRAM write enable.
REQ-015 frame_count  out  8  completed frames, wraps 255->0.
REQ-016 busy  out  1  high in CAPTURE or FLUSH.
REQ-017 overflow  out  1  sticky flag: a packed word was dropped.

Function
REQ-018 Each pixel converts to 6-bit RGB222 {R[15:14],G[10:9],B[4:3]}, zero-extended to a byte.
REQ-019 Even pixel index goes to sp_wdata[7:0]; odd index goes to [15:8]; word address = pixel index >> 1.
REQ-020 The packed word and its address are pushed into the FIFO on the cycle after the odd pixel is accepted.
REQ-021 States: IDLE, CAPTURE, FLUSH, DONE.
REQ-022 IDLE -> CAPTURE on frame_start; the pixel index clears to 0.
REQ-023 In CAPTURE, a pixel is accepted on pix_valid while index < H_PIX*V_PIX; further pixels are ignored.
REQ-024 CAPTURE -> FLUSH on frame_end, or when index reaches H_PIX*V_PIX.
REQ-025 On entry to FLUSH with an odd pixel count, the partial word is pushed with the high byte 0 and sp_maskwe 4'b0011; all other writes use 4'b1111.
REQ-026 FLUSH -> DONE when the FIFO is empty and no write is in flight.
REQ-027 DONE lasts one cycle, increments frame_count, then returns to IDLE.
REQ-028 Write issue: when sp_grant=1 and the FIFO is not empty, the head is popped.
REQ-029 On a pop, sp_we=1 and the registered sp_addr/sp_wdata/sp_maskwe are driven the next cycle.
REQ-030 Otherwise sp_we=0; at most one write per cycle.
REQ-031 A push to a full FIFO drops the word and sets overflow. A simultaneous pop and push on a full FIFO is not a drop.
REQ-032 frame_start in CAPTURE or FLUSH aborts the frame: FIFO and partial word are discarded, frame_count is unchanged, index clears, state is CAPTURE.
REQ-033 overflow clears only on reset or on a frame_start.
REQ-034 frame_end or pix_valid in IDLE is ignored.
REQ-035 pix_valid and frame_end in the same cycle: the pixel is accepted first, then the frame is flushed.

Reset
REQ-036 Reset returns the block to IDLE and empties the FIFO.
REQ-037 On reset, sp_we=0, sp_addr=0, sp_wdata=0, sp_maskwe=0, frame_count=0, busy=0, overflow=0.
REQ-038 Reset mid-frame discards all pending data.

Structure
REQ-039 A shared package holds the state encoding, RGB565->RGB222 conversion constants, and the default H_PIX/V_PIX.
REQ-040 The FIFO is sub-module fb_fifo: synchronous, parameterized width/depth, with full/empty flags.

Verification
REQ-041 Scenario 1: frame_start, pixels 0xF800 then 0x07E0, sp_grant=1 -> one write: addr 0, wdata 0x0C30, mask 4'b1111.
REQ-042 Scenario 2: 19200 pixels of 0xFFFF, grant always high -> 9600 writes at addr 0..9599, wdata 0x3F3F, frame_count 1, busy low.
REQ-043 Scenario 3: 3 pixels then frame_end -> addr 1 written with mask 4'b0011 and high byte 0.
REQ-044 Scenario 4: sp_grant=0 while 6 words are produced, FIFO_DEPTH=4 -> overflow=1, and the first 4 words are written once grant returns.
REQ-045 Scenario 5: frame_start mid-capture at index 100 -> no stale writes; the next write is at addr 0.
REQ-046 Scenario 6: reset asserted during FLUSH -> all outputs at reset values the next cycle; frame_count stays 0.
